// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Bundles every handshake and bus signal around the memory-access stage:
//   the EX->MS handoff, the MS->WB handoff, the decode forwarding bus, the
//   data-SRAM response and the flush requests coming back from WB.
//   Modports:
//     slave  - the mem_stage view (consumes EX/SRAM/WB inputs, drives outputs)
//     master - the surrounding pipeline / testbench view
//   Ports in the bundle:
//     ms_allowin        MS accepts from EX this cycle
//     es_to_ms_valid    EX presents a valid instruction
//     es_to_ms_bus      EX payload (ES_TO_MS_BUS_WD bits)
//     es_req_pending    EX holds a handshaken request not yet accepted by MS
//     ws_allowin        WB accepts
//     ms_to_ws_valid    valid to WB
//     ms_to_ws_bus      WB payload (MS_TO_WS_BUS_WD bits)
//     ms_to_ds_bus      {fwd_valid, load_wait, dest[4:0], final_result[31:0]}
//     ms_excp_block     MS holds a valid exception or ertn
//     data_sram_data_ok one response per request, in order
//     data_sram_rdata   response data
//     excp_flush        exception flush from WB
//     ertn_flush        ertn flush from WB
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 132,
  parameter int MS_TO_WS_BUS_WD = 126
);
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       es_req_pending;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [38:0]                ms_to_ds_bus;
  logic                       ms_excp_block;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       excp_flush;
  logic                       ertn_flush;

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, es_req_pending, ws_allowin,
           data_sram_data_ok, data_sram_rdata, excp_flush, ertn_flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus,
           ms_excp_block
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus, es_req_pending, ws_allowin,
           data_sram_data_ok, data_sram_rdata, excp_flush, ertn_flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus,
           ms_excp_block
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage of the five-stage in-order pipeline (EX -> MS -> WB).
//   Holds one instruction, waits for the data-SRAM response of the load or
//   store EX issued, extracts and extends load data, forwards the result to
//   decode and hands the instruction (with exception/CSR info) to WB.
//   Responses that belong to instructions killed by a flush are counted and
//   silently dropped.
//   Ports:
//     clk    - clock
//     resetn - synchronous active-low reset
//     ms     - mem_stage_if.slave bundle (see mem_stage_if.sv)
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  ms
);

  localparam int ES_TO_MS_BUS_WD = 132;

  // EX payload layout, MSB first. The top bit is a spare and carries nothing.
  typedef struct packed {
    logic        rsvd;
    logic [6:0]  excp_num;
    logic        csr_we;
    logic [13:0] csr_idx;
    logic [31:0] csr_result;
    logic        inst_ertn;
    logic        excp;
    logic        mem_req;
    logic        mem_ld;
    logic [2:0]  ld_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  logic        ms_valid_reg;
  es_bus_t     es_to_ms_bus_reg;
  logic        got_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  discard_cnt_reg;
  logic [1:0]  discard_cnt_next;

  logic        flush;
  logic        ok_eff;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  logic        leaving;
  logic        capture;
  logic        own_pending;
  logic [31:0] rd;
  logic [7:0]  rd_byte [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] final_result;
  logic        fwd_valid;
  logic        load_wait;
  logic        unused_rsvd;

  assign unused_rsvd = es_to_ms_bus_reg.rsvd;

  assign flush = ms.excp_flush | ms.ertn_flush;

  // A response only counts for us once all stale responses have drained.
  assign ok_eff = ms.data_sram_data_ok & (discard_cnt_reg == 2'd0);

  assign ms_ready_go    = ~es_to_ms_bus_reg.mem_req | got_reg | ok_eff;
  assign ms_allowin     = ~ms_valid_reg | (ms_ready_go & ms.ws_allowin);
  assign ms_to_ws_valid = ms_valid_reg & ms_ready_go & ~flush;
  assign leaving        = ms_to_ws_valid & ms.ws_allowin;

  // Buffer the response only if the instruction cannot leave with it this
  // cycle; otherwise it is consumed straight from the SRAM port.
  assign capture = ok_eff & ms_valid_reg & es_to_ms_bus_reg.mem_req & ~got_reg
                 & ~leaving & ~flush;

  // Load data extraction
  assign rd = got_reg ? rdata_reg : ms.data_sram_rdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign rd_byte[gi] = rd[gi*8 +: 8];
  end

  always_comb begin
    ld_byte  = rd_byte[es_to_ms_bus_reg.alu_result[1:0]];
    ld_half  = es_to_ms_bus_reg.alu_result[1] ? rd[31:16] : rd[15:0];
    ld_value = rd;
    case (es_to_ms_bus_reg.ld_type)
      3'b001:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {24'd0, ld_byte};
      3'b110:  ld_value = {16'd0, ld_half};
      default: ld_value = rd;
    endcase
  end

  assign final_result = es_to_ms_bus_reg.mem_ld ? ld_value
                                                : es_to_ms_bus_reg.alu_result;

  assign fwd_valid = ms_valid_reg & es_to_ms_bus_reg.gr_we;
  assign load_wait = ms_valid_reg & es_to_ms_bus_reg.mem_ld & ~got_reg & ~ok_eff;

  // Discard bookkeeping. Our own request is still outstanding at a flush
  // unless it was already buffered or its response is the one arriving now.
  // Gating on ok_eff (rather than raw data_ok) keeps the count right when a
  // stale response arrives in the flush cycle while our own is still out.
  assign own_pending = ms_valid_reg & es_to_ms_bus_reg.mem_req & ~got_reg
                     & ~ok_eff;

  always_comb begin
    discard_cnt_next = discard_cnt_reg;
    if (flush) begin
      discard_cnt_next = discard_cnt_next + {1'b0, own_pending}
                                          + {1'b0, ms.es_req_pending};
    end
    if (ms.data_sram_data_ok && (discard_cnt_reg != 2'd0)) begin
      discard_cnt_next = discard_cnt_next - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_reg     <= 1'b0;
      es_to_ms_bus_reg <= '0;
      got_reg          <= 1'b0;
      rdata_reg        <= 32'd0;
      discard_cnt_reg  <= 2'd0;
    end else begin
      if (flush) begin
        ms_valid_reg <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_reg <= ms.es_to_ms_valid;
      end

      if (ms.es_to_ms_valid && ms_allowin) begin
        es_to_ms_bus_reg <= es_bus_t'(ms.es_to_ms_bus);
      end

      if (flush || leaving) begin
        got_reg <= 1'b0;
      end else if (capture) begin
        got_reg <= 1'b1;
      end

      if (capture) begin
        rdata_reg <= ms.data_sram_rdata;
      end

      discard_cnt_reg <= discard_cnt_next;
    end
  end

  assign ms.ms_allowin     = ms_allowin;
  assign ms.ms_to_ws_valid = ms_to_ws_valid;
  assign ms.ms_to_ws_bus   = {es_to_ms_bus_reg.excp_num,
                              es_to_ms_bus_reg.csr_we,
                              es_to_ms_bus_reg.csr_idx,
                              es_to_ms_bus_reg.csr_result,
                              es_to_ms_bus_reg.inst_ertn,
                              es_to_ms_bus_reg.excp,
                              es_to_ms_bus_reg.gr_we,
                              es_to_ms_bus_reg.dest,
                              final_result,
                              es_to_ms_bus_reg.pc};
  assign ms.ms_to_ds_bus   = {fwd_valid, load_wait, es_to_ms_bus_reg.dest,
                              final_result};
  assign ms.ms_excp_block  = ms_valid_reg
                           & (es_to_ms_bus_reg.excp | es_to_ms_bus_reg.inst_ertn);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if ms_if ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ms     (ms_if)
  );

  typedef struct packed {
    logic [6:0]  excp_num;
    logic        csr_we;
    logic [13:0] csr_idx;
    logic [31:0] csr_result;
    logic        inst_ertn;
    logic        excp;
    logic        mem_req;
    logic        mem_ld;
    logic [2:0]  ld_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } instr_t;

  typedef struct {
    logic        mem_ld;
    logic [2:0]  ld_type;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] o_final, o_pc, o_csr_result;
  logic [6:0]  o_excp_num;
  logic        o_fwd, o_lw;
  assign o_final      = ms_if.ms_to_ws_bus[63:32];
  assign o_pc         = ms_if.ms_to_ws_bus[31:0];
  assign o_csr_result = ms_if.ms_to_ws_bus[103:72];
  assign o_excp_num   = ms_if.ms_to_ws_bus[125:119];
  assign o_fwd        = ms_if.ms_to_ds_bus[38];
  assign o_lw         = ms_if.ms_to_ds_bus[37];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [131:0] pack(input instr_t i);
    return {1'b0, i};
  endfunction

  function automatic instr_t mk_alu(input logic [31:0] res, input logic [4:0] dest,
                                    input logic [31:0] pc);
    instr_t i;
    i = '0;
    i.alu_result = res;
    i.dest       = dest;
    i.gr_we      = 1'b1;
    i.pc         = pc;
    return i;
  endfunction

  function automatic instr_t mk_ld(input logic [2:0] t, input logic [31:0] addr,
                                   input logic [4:0] dest, input logic [31:0] pc);
    instr_t i;
    i = mk_alu(addr, dest, pc);
    i.mem_req = 1'b1;
    i.mem_ld  = 1'b1;
    i.ld_type = t;
    return i;
  endfunction

  // Reference load extraction from the encoding rules, plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (int'(a) * 8)) & 32'hFF;
    h = (d >> (int'(a[1]) * 16)) & 32'hFFFF;
    case (t)
      3'b001:  return (b >= 128) ? b - 256 : b;
      3'b010:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return b;
      3'b110:  return h;
      default: return d;
    endcase
  endfunction

  task automatic idle();
    ms_if.es_to_ms_valid    = 1'b0;
    ms_if.es_to_ms_bus      = '0;
    ms_if.es_req_pending    = 1'b0;
    ms_if.ws_allowin        = 1'b1;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'd0;
    ms_if.excp_flush        = 1'b0;
    ms_if.ertn_flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input instr_t i);
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = pack(i);
  endtask

  vec_t   vecs[9];
  instr_t ins;

  // random-test model state
  instr_t      cur_ex, m_instr;
  bit          ex_has, m_valid, m_got, resp_now, exp_done, leave, accept;
  int          m_delay, done_cnt, kind;
  logic [31:0] m_data, exp_fin;

  initial begin
    vecs[0] = '{1'b0, 3'b000, 32'h1234_5678, 32'h0,         32'h1234_5678};
    vecs[1] = '{1'b1, 3'b000, 32'h0000_0100, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[2] = '{1'b1, 3'b001, 32'h0000_0101, 32'h1122_8033, 32'hFFFF_FF80};
    vecs[3] = '{1'b1, 3'b101, 32'h0000_0102, 32'h11F2_8033, 32'h0000_00F2};
    vecs[4] = '{1'b1, 3'b010, 32'h0000_0202, 32'h9ABC_1234, 32'hFFFF_9ABC};
    vecs[5] = '{1'b1, 3'b110, 32'h0000_0300, 32'h9ABC_8234, 32'h0000_8234};
    vecs[6] = '{1'b1, 3'b001, 32'h0000_0400, 32'h0000_007F, 32'h0000_007F};
    vecs[7] = '{1'b1, 3'b111, 32'h0000_0503, 32'h8765_4321, 32'h8765_4321};
    vecs[8] = '{1'b1, 3'b010, 32'h0000_0600, 32'h0000_F00F, 32'hFFFF_F00F};

    idle();
    resetn = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_allowin", 32'(ms_if.ms_allowin), 32'd1);
    check("rst_to_ws_valid", 32'(ms_if.ms_to_ws_valid), 32'd0);
    check("rst_excp_block", 32'(ms_if.ms_excp_block), 32'd0);
    check("rst_fwd_valid", 32'(o_fwd), 32'd0);
    check("rst_load_wait", 32'(o_lw), 32'd0);
    tick();
    resetn = 1'b1;

    // ALU op passes through in one cycle
    present(mk_alu(32'h1234_5678, 5'd5, 32'h1C00_0000));
    @(negedge clk);
    check("alu_allowin", 32'(ms_if.ms_allowin), 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("alu_valid", 32'(ms_if.ms_to_ws_valid), 32'd1);
    check("alu_final", o_final, 32'h1234_5678);
    check("alu_fwd", 32'(o_fwd), 32'd1);
    check("alu_load_wait", 32'(o_lw), 32'd0);
    $display("txn alu: final=%h", o_final);
    tick();

    // Table: response arrives in the first MS cycle
    for (int v = 0; v < 9; v++) begin
      ins = vecs[v].mem_ld ? mk_ld(vecs[v].ld_type, vecs[v].addr, 5'd3, 32'h100 + 32'(v))
                           : mk_alu(vecs[v].addr, 5'd3, 32'h100 + 32'(v));
      present(ins);
      tick();
      idle();
      ms_if.data_sram_data_ok = vecs[v].mem_ld;
      ms_if.data_sram_rdata   = vecs[v].rdata;
      @(negedge clk);
      check("vec_valid", 32'(ms_if.ms_to_ws_valid), 32'd1);
      check("vec_final", o_final, vecs[v].exp);
      $display("txn vec %0d: type=%b addr=%h rdata=%h final=%h", v, vecs[v].ld_type,
               vecs[v].addr, vecs[v].rdata, o_final);
      tick();
      idle();
    end

    // Loads whose response is one cycle late
    for (int k = 0; k < 2; k++) begin
      present(k == 0 ? mk_ld(3'b001, 32'h2003, 5'd9, 32'h200)
                     : mk_ld(3'b110, 32'h2002, 5'd9, 32'h204));
      tick();
      idle();
      ms_if.data_sram_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("late_load_wait", 32'(o_lw), 32'd1);
      check("late_valid_early", 32'(ms_if.ms_to_ws_valid), 32'd0);
      tick();
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = 32'h80FF_0000;
      @(negedge clk);
      check("late_valid", 32'(ms_if.ms_to_ws_valid), 32'd1);
      check("late_load_wait_clr", 32'(o_lw), 32'd0);
      check("late_final", o_final, k == 0 ? 32'hFFFF_FF80 : 32'h0000_80FF);
      $display("txn late load %0d: final=%h", k, o_final);
      tick();
      idle();
    end

    // Back-pressure holds the buffered response
    present(mk_ld(3'b000, 32'h3000, 5'd4, 32'h300));
    tick();
    idle();
    ms_if.ws_allowin        = 1'b0;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("bp_final0", o_final, 32'hDEAD_BEEF);
    for (int c = 0; c < 2; c++) begin
      tick();
      ms_if.data_sram_data_ok = 1'b0;
      ms_if.data_sram_rdata   = 32'h0;
      @(negedge clk);
      check("bp_valid_hold", 32'(ms_if.ms_to_ws_valid), 32'd1);
      check("bp_final_hold", o_final, 32'hDEAD_BEEF);
    end
    tick();
    ms_if.ws_allowin = 1'b1;
    @(negedge clk);
    check("bp_final_release", o_final, 32'hDEAD_BEEF);
    $display("txn back-pressure: final=%h", o_final);
    tick();
    @(negedge clk);
    check("bp_left", 32'(ms_if.ms_to_ws_valid), 32'd0);
    tick();

    // Flush with own request and an EX request outstanding: two discards
    present(mk_ld(3'b000, 32'h4000, 5'd6, 32'h400));
    tick();
    idle();
    ms_if.excp_flush     = 1'b1;
    ms_if.es_req_pending = 1'b1;
    present(mk_alu(32'h7, 5'd7, 32'h404));
    @(negedge clk);
    check("fl_valid", 32'(ms_if.ms_to_ws_valid), 32'd0);
    tick();
    idle();
    present(mk_ld(3'b000, 32'h5000, 5'd8, 32'h500));
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hBAD0_0001;
    @(negedge clk);
    check("fl_dropped", 32'(o_fwd), 32'd0);
    check("fl_allowin", 32'(ms_if.ms_allowin), 32'd1);
    tick();
    idle();
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hBAD0_0002;
    @(negedge clk);
    check("fl_discard2_valid", 32'(ms_if.ms_to_ws_valid), 32'd0);
    check("fl_discard2_wait", 32'(o_lw), 32'd1);
    tick();
    ms_if.data_sram_rdata = 32'h600D_0000;
    @(negedge clk);
    check("fl_new_valid", 32'(ms_if.ms_to_ws_valid), 32'd1);
    check("fl_new_final", o_final, 32'h600D_0000);
    check("fl_new_pc", o_pc, 32'h500);
    $display("txn flush-discard: final=%h", o_final);
    tick();
    idle();

    // Flush coincident with own response: nothing to discard
    present(mk_ld(3'b000, 32'h6000, 5'd7, 32'h600));
    tick();
    idle();
    ms_if.ertn_flush        = 1'b1;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h1111_1111;
    present(mk_alu(32'h9, 5'd9, 32'h604));
    @(negedge clk);
    check("co_valid", 32'(ms_if.ms_to_ws_valid), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("co_dropped", 32'(o_fwd), 32'd0);
    present(mk_ld(3'b000, 32'h7000, 5'd10, 32'h700));
    tick();
    idle();
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h2222_2222;
    @(negedge clk);
    check("co_next_valid", 32'(ms_if.ms_to_ws_valid), 32'd1);
    check("co_next_final", o_final, 32'h2222_2222);
    $display("txn flush-coincident: final=%h", o_final);
    tick();
    idle();

    // Exception instruction
    ins = '0;
    ins.excp       = 1'b1;
    ins.excp_num   = 7'h15;
    ins.csr_we     = 1'b1;
    ins.csr_result = 32'hA5A5_0001;
    ins.pc         = 32'h800;
    present(ins);
    tick();
    idle();
    @(negedge clk);
    check("ex_block", 32'(ms_if.ms_excp_block), 32'd1);
    check("ex_valid", 32'(ms_if.ms_to_ws_valid), 32'd1);
    check("ex_num", 32'(o_excp_num), 32'h15);
    check("ex_csr_result", o_csr_result, 32'hA5A5_0001);
    $display("txn exception: excp_num=%h", o_excp_num);
    tick();
    @(negedge clk);
    check("ex_block_clr", 32'(ms_if.ms_excp_block), 32'd0);
    tick();

    // Randomized traffic against a transaction-level model
    ex_has   = 0;
    m_valid  = 0;
    m_got    = 0;
    m_delay  = 0;
    m_data   = 0;
    done_cnt = 0;
    cur_ex   = '0;
    m_instr  = '0;
    for (int cyc = 0; cyc < 4000 && done_cnt < 150; cyc++) begin
      if (!ex_has && $urandom_range(0, 2) != 0) begin
        kind = int'($urandom_range(0, 2));
        cur_ex = '0;
        cur_ex.alu_result = $urandom();
        cur_ex.pc         = $urandom();
        cur_ex.dest       = 5'($urandom());
        cur_ex.gr_we      = 1'($urandom());
        if (kind != 0) cur_ex.mem_req = 1'b1;
        if (kind == 1) begin
          cur_ex.mem_ld  = 1'b1;
          cur_ex.ld_type = 3'($urandom());
          cur_ex.gr_we   = 1'b1;
        end
        ex_has = 1;
      end
      ms_if.es_to_ms_valid    = ex_has;
      ms_if.es_to_ms_bus      = pack(cur_ex);
      ms_if.ws_allowin        = ($urandom_range(0, 3) != 0);
      resp_now = m_valid && m_instr.mem_req && !m_got && (m_delay == 0);
      ms_if.data_sram_data_ok = resp_now;
      ms_if.data_sram_rdata   = resp_now ? m_data : $urandom();
      @(negedge clk);
      exp_done = m_valid && (!m_instr.mem_req || m_got || resp_now);
      check("rnd_valid", 32'(ms_if.ms_to_ws_valid), 32'(exp_done));
      check("rnd_load_wait", 32'(o_lw),
            32'(m_valid && m_instr.mem_ld && !m_got && !resp_now));
      check("rnd_fwd", 32'(o_fwd), 32'(m_valid && m_instr.gr_we));
      leave  = exp_done && ms_if.ws_allowin;
      accept = ex_has && (!m_valid || leave);
      check("rnd_allowin", 32'(ms_if.ms_allowin), 32'(!m_valid || leave));
      if (leave) begin
        exp_fin = m_instr.mem_ld ? ref_load(m_instr.ld_type, m_instr.alu_result[1:0], m_data)
                                 : m_instr.alu_result;
        check("rnd_final", o_final, exp_fin);
        check("rnd_pc", o_pc, m_instr.pc);
        $display("txn rnd %0d: pc=%h ld=%b type=%b final=%h", done_cnt, o_pc,
                 m_instr.mem_ld, m_instr.ld_type, o_final);
        done_cnt++;
      end
      if (resp_now) m_got = 1;
      else if (m_valid && m_delay > 0) m_delay--;
      if (leave) m_valid = 0;
      if (accept) begin
        m_instr = cur_ex;
        m_valid = 1;
        m_got   = 0;
        m_delay = int'($urandom_range(0, 3));
        m_data  = $urandom();
        ex_has  = 0;
      end
      tick();
    end
    check("rnd_completed", 32'(done_cnt), 32'd150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
